// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, register
// access modes and the helper that maps the parameter masks onto a mode.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        RW  = 2'd0,
        RO  = 2'd1,
        W1C = 2'd2
    } reg_mode_t;

    // RO takes precedence should both mask bits ever be set for one index.
    function automatic reg_mode_t reg_mode(input logic ro, input logic w1c);
        if (ro) begin
            return RO;
        end else if (w1c) begin
            return W1C;
        end
        return RW;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    resp_t                     bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    resp_t                     rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_skid.sv
// One-entry skid buffer: passes a beat straight through when the consumer is
// ready, otherwise parks it and drops in_ready until the consumer takes it.
module axi_lite_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             full;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !full;
    assign out_valid = full || in_valid;
    assign out_data  = full ? data_q : in_data;

    // Park an unconsumed beat; release it once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (full) begin
            if (out_ready) full <= 1'b0;
        end else if (in_valid && !out_ready) begin
            full   <= 1'b1;
            data_q <= in_data;
        end
    end
endmodule

// File: rtl/axi_lite_regs.sv
// Parametrised AXI4-Lite register bank with RW, RO (hardware status) and
// sticky write-1-to-clear registers, decode errors and per-register strobes.
module axi_lite_regs
    import axi_lite_pkg::*;
#(
    parameter int                            DATA_WIDTH  = 32,
    parameter int                            NUM_REGS    = 16,
    parameter int                            ADDR_WIDTH  = 16,
    parameter logic [NUM_REGS-1:0]           RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]           W1C_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    axi_lite_if.slave                      s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] w1c_set,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    logic                  aw_valid, w_valid, ar_valid;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data, lane_mask, wr_bits, rd_val;
    logic [STRB_W-1:0]     w_strb;
    logic                  b_free, commit, wr_err, ro_hit, rd_err, ar_take;
    logic [31:0]           widx, ridx;
    logic [NUM_REGS-1:0]   we_vec;
    logic                  bvalid_q, rvalid_q;
    resp_t                 bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused_bus;

    // Out of range index or any nonzero bit above the index field.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] idx;
        idx = 32'(a[LSB +: IDX_W]);
        return (idx >= 32'(NUM_REGS)) || ((a >> (LSB + IDX_W)) != '0);
    endfunction

    assign unused_bus = ^{s_axi.awprot, s_axi.arprot, aw_addr, ar_addr};

    assign b_free  = !bvalid_q || s_axi.bready;
    assign commit  = aw_valid && w_valid && b_free;
    assign ar_take = ar_valid && (!rvalid_q || s_axi.rready);

    axi_lite_skid #(.WIDTH(ADDR_WIDTH)) u_aw_skid (
        .clk(s_axi_aclk), .rst(s_axi_areset),
        .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(s_axi.awaddr),
        .out_valid(aw_valid), .out_ready(w_valid && b_free), .out_data(aw_addr)
    );

    axi_lite_skid #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_skid (
        .clk(s_axi_aclk), .rst(s_axi_areset),
        .in_valid(s_axi.wvalid), .in_ready(s_axi.wready),
        .in_data({s_axi.wdata, s_axi.wstrb}),
        .out_valid(w_valid), .out_ready(aw_valid && b_free), .out_data({w_data, w_strb})
    );

    axi_lite_skid #(.WIDTH(ADDR_WIDTH)) u_ar_skid (
        .clk(s_axi_aclk), .rst(s_axi_areset),
        .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(s_axi.araddr),
        .out_valid(ar_valid), .out_ready(!rvalid_q || s_axi.rready), .out_data(ar_addr)
    );

    // Write decode: byte-lane mask, error classification and per-register enables.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < STRB_W; b++) lane_mask[b*8 +: 8] = {8{w_strb[b]}};
        wr_bits = w_data & lane_mask;
        widx    = 32'(aw_addr[LSB +: IDX_W]);
        ro_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == 32'(i) && reg_mode(RO_MASK[i], W1C_MASK[i]) == RO) ro_hit = 1'b1;
        end
        wr_err = addr_err(aw_addr) || ro_hit;
        we_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && !wr_err && widx == 32'(i)) we_vec[i] = 1'b1;
        end
    end

    // Read mux over the live register view (pre-commit on a same-cycle write).
    always_comb begin
        ridx   = 32'(ar_addr[LSB +: IDX_W]);
        rd_err = addr_err(ar_addr);
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == 32'(i)) rd_val = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_mode_t MODE = reg_mode(RO_MASK[i], W1C_MASK[i]);
        if (MODE == RO) begin : g_ro
            logic unused_set;
            assign unused_set = ^w1c_set[i*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (MODE == W1C) begin : g_w1c
            logic [DATA_WIDTH-1:0] q;
            logic                  unused_in;
            assign unused_in = ^reg_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = q;
            // Sticky flags: set pulses win over a same-cycle clear.
            always_ff @(posedge s_axi_aclk) begin
                if (s_axi_areset) q <= '0;
                else q <= (q & ~({DATA_WIDTH{we_vec[i]}} & wr_bits))
                          | w1c_set[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] q;
            logic                  unused_in;
            assign unused_in = ^{reg_in[i*DATA_WIDTH +: DATA_WIDTH],
                                 w1c_set[i*DATA_WIDTH +: DATA_WIDTH]};
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = q;
            // Plain storage updated on strobed byte lanes.
            always_ff @(posedge s_axi_aclk) begin
                if (s_axi_areset) q <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
                else if (we_vec[i]) q <= (q & ~lane_mask) | wr_bits;
            end
        end
    end

    // Write response and register strobes follow the commit by one cycle.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= we_vec;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? SLVERR : OKAY;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read response register; held while the master stalls R.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else if (ar_take) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err ? '0 : rd_val;
            rresp_q  <= rd_err ? SLVERR : OKAY;
        end else if (s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi.bvalid = bvalid_q;
    assign s_axi.bresp  = bresp_q;
    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rdata  = rdata_q;
    assign s_axi.rresp  = rresp_q;
endmodule

// File: tb/tb_axi_lite_regs.sv
// Self-checking bench for axi_lite_regs: table of write/read vectors plus
// hand sequences for buffering, W1C races, random R stalls and reset.
module tb_axi_lite_regs;
    import axi_lite_pkg::*;

    localparam logic [15:0]  RO_M  = 16'h0008;
    localparam logic [15:0]  W1C_M = 16'h0004;
    localparam logic [511:0] RV    = {320'h0, 32'hA5A50001, 160'h0};

    logic         clk = 1'b0;
    logic         areset;
    logic [511:0] reg_out, reg_in, w1c_set;
    logic [15:0]  wr_pulse;
    int           checks = 0;
    int           errors = 0;

    axi_lite_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bif ();

    axi_lite_regs #(
        .DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(16),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VALUE(RV)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset), .s_axi(bif),
        .reg_out(reg_out), .reg_in(reg_in), .w1c_set(w1c_set), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
        logic [15:0] pulse;
    } vec_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    rexp_t       r_e;
    logic [1:0]  b_e;
    bit          stall_prev = 1'b0;
    logic [33:0] held;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rout(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard and R stall stability monitor.
    always @(negedge clk) begin
        if (!areset) begin
            if (bif.rvalid && bif.rready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got rdata %h with no read outstanding", bif.rdata);
                end else begin
                    r_e = rq.pop_front();
                    chk("rdata", 64'(bif.rdata), 64'(r_e.data));
                    chk("rresp", 64'(bif.rresp), 64'(r_e.resp));
                end
            end
            if (stall_prev && bif.rvalid)
                chk("r_stall_hold", 64'({bif.rresp, bif.rdata}), 64'(held));
            stall_prev = bif.rvalid && !bif.rready;
            held = {bif.rresp, bif.rdata};
            if (bif.bvalid && bif.bready) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got bresp %b with no write outstanding", bif.bresp);
                end else begin
                    b_e = bq.pop_front();
                    chk("bresp", 64'(bif.bresp), 64'(b_e));
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] eresp,
                             input logic [15:0] epulse);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        bif.awvalid = 1'b1; bif.awaddr = addr;
        bif.wvalid  = 1'b1; bif.wdata  = data; bif.wstrb = strb;
        bq.push_back(eresp);
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_hs = bif.awvalid && bif.awready;
            w_hs  = bif.wvalid && bif.wready;
            cyc();
            if (aw_hs) begin aw_done = 1; bif.awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; bif.wvalid  = 1'b0; end
            n++;
        end
        bif.awvalid = 1'b0; bif.wvalid = 1'b0;
        if (!(aw_done && w_done)) chk("write_handshake_timeout", 64'(n), 64'(0));
        chk("wr_pulse", 64'(wr_pulse), 64'(epulse));
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [31:0] edata,
                            input logic [1:0] eresp);
        bit done = 0;
        int n = 0;
        bif.arvalid = 1'b1; bif.araddr = addr;
        while (!done && n < 50) begin
            @(negedge clk);
            if (bif.arvalid && bif.arready) begin
                rq.push_back('{edata, eresp});
                done = 1;
            end
            cyc();
            n++;
        end
        bif.arvalid = 1'b0;
        if (!done) chk("read_handshake_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_r", 64'(rq.size()), 64'(0));
        chk("drain_b", 64'(bq.size()), 64'(0));
    endtask

    initial begin
        logic [15:0] raddr[5];
        rexp_t       rval[5];

        tbl[0]  = '{0, 16'h0014, 32'h0,        4'h0, 32'hA5A50001, 2'b00, 16'h0};
        tbl[1]  = '{1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 16'h0002};
        tbl[2]  = '{0, 16'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 16'h0};
        tbl[3]  = '{1, 16'h0010, 32'h12345678, 4'h5, 32'h0,        2'b00, 16'h0010};
        tbl[4]  = '{0, 16'h0010, 32'h0,        4'h0, 32'h00340078, 2'b00, 16'h0};
        tbl[5]  = '{0, 16'h0040, 32'h0,        4'h0, 32'h0,        2'b10, 16'h0};
        tbl[6]  = '{1, 16'h0040, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 16'h0};
        tbl[7]  = '{0, 16'h1004, 32'h0,        4'h0, 32'h0,        2'b10, 16'h0};
        tbl[8]  = '{1, 16'h000C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 16'h0};
        tbl[9]  = '{0, 16'h000C, 32'h0,        4'h0, 32'hCAFE0003, 2'b00, 16'h0};
        tbl[10] = '{1, 16'h0006, 32'h0000AB00, 4'h2, 32'h0,        2'b00, 16'h0002};
        tbl[11] = '{0, 16'h0004, 32'h0,        4'h0, 32'hDEADABEF, 2'b00, 16'h0};
        tbl[12] = '{1, 16'h0014, 32'h00000000, 4'h8, 32'h0,        2'b00, 16'h0020};
        tbl[13] = '{0, 16'h0014, 32'h0,        4'h0, 32'h00A50001, 2'b00, 16'h0};

        areset = 1'b1;
        bif.awvalid = 0; bif.awaddr = '0; bif.awprot = 3'b010;
        bif.wvalid = 0;  bif.wdata = '0;  bif.wstrb = '0;
        bif.arvalid = 0; bif.araddr = '0; bif.arprot = 3'b001;
        bif.rready = 1;  bif.bready = 1;
        reg_in = {16{32'h5A5A5A5A}};
        reg_in[96 +: 32] = 32'hCAFE0003;
        w1c_set = '0;
        repeat (3) cyc();

        chk("rst_awready", 64'(bif.awready), 64'(1));
        chk("rst_wready",  64'(bif.wready),  64'(1));
        chk("rst_arready", 64'(bif.arready), 64'(1));
        chk("rst_bvalid",  64'(bif.bvalid),  64'(0));
        chk("rst_rvalid",  64'(bif.rvalid),  64'(0));
        chk("rst_rdata",   64'(bif.rdata),   64'(0));
        chk("rst_wr_pulse", 64'(wr_pulse),   64'(0));
        chk("rst_reg5",    64'(rout(5)),     64'h A5A50001);
        chk("ro_reflect",  64'(rout(3)),     64'h CAFE0003);
        areset = 1'b0;
        cyc();

        // Table of single transactions.
        for (int k = 0; k < 14; k++) begin
            if (tbl[k].wr) begin
                axi_write(tbl[k].addr, tbl[k].data, tbl[k].strb, tbl[k].resp, tbl[k].pulse);
                cyc();
                chk("wr_pulse_one_cycle", 64'(wr_pulse), 64'(0));
                if (tbl[k].addr == 16'h000C) chk("ro_unchanged", 64'(rout(3)), 64'h CAFE0003);
            end else begin
                axi_read(tbl[k].addr, tbl[k].exp, tbl[k].resp);
            end
            drain();
        end

        // W beat arrives three cycles ahead of AW.
        bif.wvalid = 1; bif.wdata = 32'h12345678; bif.wstrb = 4'b0101;
        bq.push_back(OKAY);
        cyc();
        bif.wvalid = 0;
        chk("w_buffered_wready", 64'(bif.wready), 64'(0));
        cyc(); cyc();
        chk("w_only_no_pulse", 64'(wr_pulse), 64'(0));
        bif.awvalid = 1; bif.awaddr = 16'h0018;
        cyc();
        bif.awvalid = 0;
        chk("late_aw_pulse", 64'(wr_pulse), 64'h0040);
        chk("late_aw_reg6", 64'(rout(6)), 64'h00340078);
        chk("late_aw_wready", 64'(bif.wready), 64'(1));
        axi_read(16'h0018, 32'h00340078, OKAY);
        drain();

        // W1C: set/clear race on bit 0 keeps it set.
        w1c_set[64 +: 32] = 32'h5;
        cyc();
        w1c_set = '0;
        chk("w1c_set", 64'(rout(2)), 64'h5);
        bif.awvalid = 1; bif.awaddr = 16'h0008;
        bif.wvalid = 1; bif.wdata = 32'h1; bif.wstrb = 4'hF;
        w1c_set[64 +: 32] = 32'h1;
        bq.push_back(OKAY);
        cyc();
        bif.awvalid = 0; bif.wvalid = 0; w1c_set = '0;
        chk("w1c_race_pulse", 64'(wr_pulse), 64'h0004);
        chk("w1c_race_keep", 64'(rout(2)), 64'h5);
        axi_write(16'h0008, 32'h1, 4'hF, OKAY, 16'h0004);
        chk("w1c_clear", 64'(rout(2)), 64'h4);
        axi_read(16'h0008, 32'h4, OKAY);
        drain();

        // Back-to-back reads with random rready.
        raddr[0] = 16'h0004; rval[0] = '{32'hDEADABEF, 2'b00};
        raddr[1] = 16'h0010; rval[1] = '{32'h00340078, 2'b00};
        raddr[2] = 16'h0014; rval[2] = '{32'h00A50001, 2'b00};
        raddr[3] = 16'h0018; rval[3] = '{32'h00340078, 2'b00};
        raddr[4] = 16'h0040; rval[4] = '{32'h0,        2'b10};
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    bit done = 0;
                    int n = 0;
                    bif.arvalid = 1; bif.araddr = raddr[k % 5];
                    while (!done && n < 50) begin
                        @(negedge clk);
                        if (bif.arvalid && bif.arready) begin
                            rq.push_back(rval[k % 5]);
                            done = 1;
                        end
                        cyc();
                        n++;
                    end
                    if (!done) chk("burst_ar_timeout", 64'(k), 64'(-1));
                end
                bif.arvalid = 0;
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    cyc();
                    bif.rready = 1'($urandom_range(0, 1));
                end
                bif.rready = 1;
            end
        join
        drain();

        // Reset with a pending B and a buffered AW.
        bif.bready = 0;
        axi_write(16'h0004, 32'h11111111, 4'hF, OKAY, 16'h0002);
        cyc();
        chk("b_stalled", 64'(bif.bvalid), 64'(1));
        chk("reg1_written", 64'(rout(1)), 64'h11111111);
        bif.awvalid = 1; bif.awaddr = 16'h0010;
        cyc();
        chk("aw_buffered", 64'(bif.awready), 64'(0));
        areset = 1; bif.awvalid = 0;
        cyc();
        chk("rr_bvalid",  64'(bif.bvalid),  64'(0));
        chk("rr_awready", 64'(bif.awready), 64'(1));
        chk("rr_wready",  64'(bif.wready),  64'(1));
        chk("rr_arready", 64'(bif.arready), 64'(1));
        chk("rr_wr_pulse", 64'(wr_pulse),   64'(0));
        chk("rr_reg1", 64'(rout(1)), 64'h0);
        chk("rr_reg4", 64'(rout(4)), 64'h0);
        chk("rr_reg5", 64'(rout(5)), 64'hA5A50001);
        chk("rr_reg2", 64'(rout(2)), 64'h0);
        bq.delete();
        areset = 0; bif.bready = 1;
        repeat (3) cyc();
        chk("post_rst_bvalid", 64'(bif.bvalid), 64'(0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

Parametrised AXI4-Lite register bank, the successor to the fixed 16 × 32-bit control block. Width, depth and per-register access mode (read-write, read-only hardware status, write-1-to-clear sticky flags) are set by parameters. The block adds SLVERR decode errors and per-register write strobes to fabric logic. It sits between the PS/interconnect AXI4-Lite master and PHY datapath configuration/status logic.

## Interface
- DATA_WIDTH, 32: register and AXI data width; 32 or 64.
- NUM_REGS, 16: number of registers, ≥2.
- ADDR_WIDTH, 16: AXI address width.
- RO_MASK, '0: NUM_REGS bits; bit i=1 makes register i read-only, value from reg_in.
- W1C_MASK, '0: NUM_REGS bits; bit i=1 makes register i sticky write-1-to-clear. Must not overlap RO_MASK.
- RESET_VALUE, '0: NUM_REGS*DATA_WIDTH bits; reset contents of RW registers.
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_aw{valid,addr,prot,ready}: AXI4-Lite write address; addr ADDR_WIDTH, prot 3, ready out.
- s_axi_w{valid,data,strb,ready}: write data; data DATA_WIDTH, strb DATA_WIDTH/8, ready out.
- s_axi_b{valid,resp,ready}: write response; valid/resp out, resp 2.
- s_axi_ar{valid,addr,prot,ready}: read address, as AW.
- s_axi_r{valid,data,resp,ready}: read data; valid/data/resp out.
- reg_out  out  NUM_REGS*DATA_WIDTH  current register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_in  in  NUM_REGS*DATA_WIDTH  hardware status for RO registers; ignored elsewhere.
- w1c_set  in  NUM_REGS*DATA_WIDTH  per-bit set pulses for W1C registers; ignored elsewhere.
- wr_pulse  out  NUM_REGS  one-cycle strobe, register i written by AXI.

## Operation
- Index = addr[LSB +: IDX_W], where LSB = log2(DATA_WIDTH/8) and IDX_W = clog2(NUM_REGS). Low LSB address bits are ignored. prot is ignored.
- Decode error: index ≥ NUM_REGS, or any addr bit above LSB+IDX_W nonzero. Reads return rdata=0, rresp=SLVERR (2'b10). Writes have no effect, bresp=SLVERR.
- Write to a RO register: no effect, bresp=SLVERR, no wr_pulse.
- RW register: byte lanes with strb=1 updated.
- W1C register: each bit ORs in w1c_set every cycle. An AXI write clears bits where wdata=1 within strobed lanes. A set and a clear of the same bit in the same cycle leaves the bit set.
- RO register read returns reg_in sampled on the AR-accept cycle. reg_out for RO indices reflects reg_in.
- AW and W are independent; either may arrive first, each held in a one-entry buffer until its partner arrives.
- A write commits on the cycle both are held and B is not stalled.
- Read and write to the same register in the same cycle: the read returns the pre-commit value.

## Timing
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, rdata=0, bresp=rresp=OKAY, wr_pulse=0, RW/W1C registers=RESET_VALUE (W1C indices masked).
- Read: AR handshake on cycle N gives rvalid=1 with registered rdata/rresp on N+1. With rready held high, one read per cycle is sustained.
- Read stall: while rvalid&&!rready, rdata/rresp are held. One further AR is accepted into the skid buffer, then arready=0 until R drains.
- Write: AW and W handshakes complete by cycle N (same or different cycles). Commit happens on N. reg_out and wr_pulse update on N+1, as do bvalid and bresp. With bready high, one write per cycle is sustained.
- B stall: while bvalid&&!bready, no commit. Each of AW and W accepts at most one buffered beat, then deasserts ready.
- bvalid drops the cycle after the bready handshake, unless a new commit occurs.
- Reset mid-transaction: buffered beats are discarded, outstanding responses are dropped, and all outputs take reset values the next cycle.

## Structure
- Package axi_lite_pkg:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - reg_mode_t enum: RW, RO, W1C.
  - function deriving mode from the masks.
- Sub-module axi_lite_skid: one-entry valid/ready skid buffer parametrised on payload width. Instantiated for AR, AW (addr) and W (data+strb).
- Top level holds address decode, register array generate loop, W1C logic and response registers.

## Test plan
- Write 0xDEADBEEF strb 4'hF to addr 0x0004, then read 0x0004 → bresp OKAY, wr_pulse[1] one cycle, rdata 0xDEADBEEF, rresp OKAY.
- W beat 3 cycles before AW, then write 0x12345678 with strb 4'b0101 over reset value 0 → register reads 0x00340078.
- W1C reg 2: pulse w1c_set=0x5. AXI write 0x1 on the same cycle as a new set of bit 0 → bit 0 stays set. A second write of 0x1 → reads 0x4.
- Read addr 0x0040 (NUM_REGS=16) → rdata 0, rresp SLVERR. Write to a RO register → bresp SLVERR, reg_out unchanged, no wr_pulse.
- Back-to-back reads with rready toggled randomly → every AR returns exactly one R, in order, and rdata stays stable while stalled.
- Assert s_axi_areset with AW buffered and bvalid pending → next cycle bvalid=0, readies=1, registers at RESET_VALUE.
